// File: rtl/cell_scheduler.sv
// Raster scheduler: issues cell-center coordinates for one image pass and
// bounds the number of cells awaiting results.
//
// state | meaning
// IDLE  | waiting for start; illegal opcode pulses err
// ISSUE | presenting cells in raster order
// DRAIN | no new cells, waiting for outstanding results
// DONE  | one-cycle done pulse (err too if aborted)
module cell_scheduler #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int CELL_N  = 3,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [3:0]               opcode_in,
    input  logic [7:0]               user_in,
    input  logic                     abort,
    output logic                     cell_valid,
    input  logic                     cell_ready,
    output logic [$clog2(IMG_W)-1:0] cell_x,
    output logic [$clog2(IMG_H)-1:0] cell_y,
    output logic [3:0]               cell_op,
    output logic [7:0]               cell_user,
    output logic                     cell_last,
    input  logic                     res_valid,
    output logic                     res_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int HALF = (CELL_N - 1) / 2;
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int OW   = $clog2(MAX_OUT + 1);
    localparam logic [XW-1:0] X_LO    = XW'(HALF);
    localparam logic [XW-1:0] X_HI    = XW'(IMG_W - 1 - HALF);
    localparam logic [YW-1:0] Y_LO    = YW'(HALF);
    localparam logic [YW-1:0] Y_HI    = YW'(IMG_H - 1 - HALF);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);
    localparam logic [3:0]    OP_MAX  = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [3:0]    op_q, op_d;
    logic [7:0]    user_q, user_d;
    logic [OW-1:0] out_q, out_d;
    logic          aborted_q, aborted_d;
    logic          bad_op_q, bad_op_d;
    logic          at_end, cell_xfer, res_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            op_q      <= '0;
            user_q    <= '0;
            out_q     <= '0;
            aborted_q <= 1'b0;
            bad_op_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            op_q      <= op_d;
            user_q    <= user_d;
            out_q     <= out_d;
            aborted_q <= aborted_d;
            bad_op_q  <= bad_op_d;
        end
    end

    // A result returned on a full cycle frees a slot for a same-cycle issue.
    assign res_ready  = (out_q != '0);
    assign res_xfer   = res_valid & res_ready;
    assign cell_valid = (state_q == S_ISSUE) && ((out_q != OUT_MAX) || res_xfer);
    assign cell_xfer  = cell_valid & cell_ready;
    assign at_end     = (x_q == X_HI) && (y_q == Y_HI);
    assign cell_last  = (state_q == S_ISSUE) && at_end;
    assign cell_x     = x_q;
    assign cell_y     = y_q;
    assign cell_op    = op_q;
    assign cell_user  = user_q;
    assign busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign err        = ((state_q == S_DONE) && aborted_q) || bad_op_q;

    always_comb begin
        out_d = out_q;
        if (cell_xfer && !res_xfer) begin
            out_d = out_q + 1'b1;
        end else if (!cell_xfer && res_xfer) begin
            out_d = out_q - 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        op_d      = op_q;
        user_d    = user_q;
        aborted_d = aborted_q;
        bad_op_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (opcode_in <= OP_MAX) begin
                        op_d      = opcode_in;
                        user_d    = user_in;
                        x_d       = X_LO;
                        y_d       = Y_LO;
                        aborted_d = 1'b0;
                        state_d   = S_ISSUE;
                    end else begin
                        bad_op_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (cell_xfer && !at_end) begin
                    if (x_q == X_HI) begin
                        x_d = X_LO;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN;
                end else if (cell_xfer && at_end) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cell_scheduler.sv
// Bench for cell_scheduler on a 5x4 image: directed scenarios then random passes,
// compared cycle by cycle against a coordinate-list / outstanding-count model.
module tb_cell_scheduler;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int N  = 3;
    localparam int MO = 3;
    localparam int HF = (N - 1) / 2;

    logic       clk = 1'b0;
    logic       rst, start, abort, cell_ready, res_valid;
    logic [3:0] opcode_in;
    logic [7:0] user_in;
    logic       cell_valid, cell_last, res_ready, busy, done, err;
    logic [2:0] cell_x;
    logic [1:0] cell_y;
    logic [3:0] cell_op;
    logic [7:0] cell_user;

    always #5 clk = ~clk;

    cell_scheduler #(.IMG_W(W), .IMG_H(H), .CELL_N(N), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode_in(opcode_in), .user_in(user_in),
        .abort(abort), .cell_valid(cell_valid), .cell_ready(cell_ready),
        .cell_x(cell_x), .cell_y(cell_y), .cell_op(cell_op), .cell_user(cell_user),
        .cell_last(cell_last), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int failures = 0;

    // Model: 0 idle, 1 issuing, 2 draining, 3 done
    int         m_phase = 0;
    int         m_out = 0;
    bit         m_aborted = 0;
    bit         m_errp = 0;
    logic [3:0] m_op = '0;
    logic [7:0] m_user = '0;
    int         qx[$];
    int         qy[$];
    int         pend[$];
    int         ret_mode = 0;
    int         cyc_n = 0;
    int         n_xfer = 0, n_done = 0, n_err = 0, n_doneerr = 0;
    int         base;
    int         stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic evaluate();
        bit ev, cx, rx, was_last;
        ev = (m_phase == 1) && ((m_out < MO) || (res_valid && m_out > 0));
        chk("cell_valid", cell_valid, ev);
        chk("res_ready", res_ready, m_out > 0);
        chk("busy", busy, (m_phase == 1) || (m_phase == 2));
        chk("done", done, m_phase == 3);
        chk("err", err, ((m_phase == 3) && m_aborted) || m_errp);
        chk("cell_op", cell_op, m_op);
        chk("cell_user", cell_user, m_user);
        if (ev && qx.size() > 0) begin
            chk("cell_x", cell_x, qx[0]);
            chk("cell_y", cell_y, qy[0]);
            chk("cell_last", cell_last, qx.size() == 1);
        end
        if (done === 1'b1) n_done++;
        if (err === 1'b1) n_err++;
        if (done === 1'b1 && err === 1'b1) n_doneerr++;

        cx = ev && cell_ready;
        rx = res_valid && (m_out > 0);
        was_last = (qx.size() == 1);
        if (cx) begin
            n_xfer++;
            pend.push_back(cyc_n + 2);
        end
        if (rx && pend.size() > 0) void'(pend.pop_front());

        if (rst) begin
            m_phase = 0; m_out = 0; m_aborted = 0; m_errp = 0;
            m_op = '0; m_user = '0;
            qx.delete(); qy.delete(); pend.delete();
        end else begin
            m_errp = 0;
            m_out = m_out + int'(cx) - int'(rx);
            case (m_phase)
                0: if (start) begin
                    if (opcode_in <= 4'd11) begin
                        m_phase = 1; m_op = opcode_in; m_user = user_in; m_aborted = 0;
                        qx.delete(); qy.delete();
                        for (int y = HF; y <= H - 1 - HF; y++)
                            for (int x = HF; x <= W - 1 - HF; x++) begin
                                qx.push_back(x); qy.push_back(y);
                            end
                    end else begin
                        m_errp = 1;
                    end
                end
                1: begin
                    if (cx) begin
                        void'(qx.pop_front()); void'(qy.pop_front());
                    end
                    if (abort) m_aborted = 1;
                    if (abort || (cx && was_last)) m_phase = 2;
                end
                2: if (m_out == 0) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    endtask

    // Inputs are set just after a rising edge; outputs sampled on the falling edge.
    task automatic cycle();
        if (ret_mode == 1) res_valid = (pend.size() > 0) && (pend[0] <= cyc_n);
        else if (ret_mode == 2) res_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        #1;
        evaluate();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic begin_pass(input logic [3:0] op, input logic [7:0] usr);
        start = 1'b1; opcode_in = op; user_in = usr;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_pass(input int budget, input bit rnd);
        for (int i = 0; i < budget && m_phase != 0; i++) begin
            if (rnd) begin
                cell_ready = ($urandom_range(0, 3) != 0);
                abort = (m_phase == 1) && ($urandom_range(0, 29) == 0);
                start = ($urandom_range(0, 9) == 0);
                opcode_in = 4'($urandom);
                user_in = 8'($urandom);
            end
            cycle();
        end
        start = 1'b0; abort = 1'b0; cell_ready = 1'b1;
        chk("pass_finished", m_phase, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cell_ready = 1'b1; res_valid = 1'b0;
        opcode_in = '0; user_in = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_valid", cell_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_x", cell_x, 0);
        chk("rst_y", cell_y, 0);
        chk("rst_op", cell_op, 0);
        cycle();

        // Basic pass with results returned two cycles after issue
        ret_mode = 1; base = n_xfer;
        begin_pass(4'd5, 8'hA5);
        run_pass(60, 0);
        cycle();
        chk("basic_xfers", n_xfer - base, 6);
        chk("basic_done", n_done, 1);
        chk("basic_err", n_err, 0);

        // Illegal opcode
        base = n_xfer;
        begin_pass(4'd13, 8'h11);
        cycle();
        cycle();
        chk("badop_err", n_err, 1);
        chk("badop_xfers", n_xfer - base, 0);

        // Outstanding limit with results withheld
        ret_mode = 0; res_valid = 1'b0; base = n_xfer;
        begin_pass(4'd2, 8'h3C);
        repeat (8) cycle();
        chk("limit_xfers", n_xfer - base, MO);
        res_valid = 1'b1;
        cycle();
        res_valid = 1'b0;
        repeat (5) cycle();
        chk("limit_one_more", n_xfer - base, MO + 1);
        ret_mode = 1;
        run_pass(60, 0);

        // Backpressure at (2,1) for three cycles
        base = n_xfer; stall = 0;
        begin_pass(4'd7, 8'h5A);
        for (int i = 0; i < 60 && m_phase != 0; i++) begin
            cell_ready = !((m_phase == 1) && qx.size() > 0 && qx[0] == 2 && qy[0] == 1 && stall < 3);
            if (!cell_ready) stall++;
            cycle();
        end
        cell_ready = 1'b1;
        chk("stall_cycles", stall, 3);
        chk("stall_xfers", n_xfer - base, 6);
        chk("stall_done", n_done, 3);

        // Abort after two transfers
        ret_mode = 0; res_valid = 1'b0; base = n_xfer;
        begin_pass(4'd11, 8'hC3);
        for (int i = 0; i < 20 && (n_xfer - base) < 2; i++) cycle();
        cell_ready = 1'b0; abort = 1'b1;
        cycle();
        abort = 1'b0; cell_ready = 1'b1;
        repeat (3) cycle();
        chk("abort_xfers", n_xfer - base, 2);
        ret_mode = 1; base = n_doneerr;
        run_pass(40, 0);
        chk("abort_done_err", n_doneerr - base, 1);

        // Reset mid-pass with three outstanding, stale results afterwards
        ret_mode = 0; res_valid = 1'b0; base = n_xfer;
        begin_pass(4'd1, 8'h99);
        for (int i = 0; i < 20 && (n_xfer - base) < 3; i++) cycle();
        chk("pre_rst_xfers", n_xfer - base, 3);
        rst = 1'b1; res_valid = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_valid", cell_valid, 0);
        chk("mid_rst_ready", res_ready, 0);
        chk("mid_rst_x", cell_x, 0);
        repeat (2) cycle();
        res_valid = 1'b0; ret_mode = 1;
        begin_pass(4'd11, 8'hFF);
        run_pass(60, 0);

        // Random passes
        ret_mode = 2;
        for (int p = 0; p < 8; p++) begin
            begin_pass(4'($urandom_range(0, 15)), 8'($urandom));
            run_pass(400, 1);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cell_scheduler.md
CELL_SCHEDULER -- requirements
Module: cell_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 480, meaning image height in pixels.
REQ-003 SHALL have parameter CELL_N, default 3, meaning cell edge (odd, at least 3); HALF = (CELL_N-1)/2.
REQ-004 SHALL have parameter MAX_OUT, default 4, meaning the maximum number of issued cells awaiting a result.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: starts a pass over the image.
REQ-008 SHALL have port opcode_in, input, 4 bits: opcode for the pass (ADD=0 .. AVG=11).
REQ-009 SHALL have port user_in, input, 8 bits: immediate operand for the pass.
REQ-010 SHALL have port abort, input, 1 bit: stops issuing cells and drains outstanding results.
REQ-011 SHALL have port cell_valid, output, 1 bit: a cell request is presented.
REQ-012 SHALL have port cell_ready, input, 1 bit: the cell processor accepts the request.
REQ-013 SHALL have port cell_x, output, clog2(IMG_W) bits: center-pixel column.
REQ-014 SHALL have port cell_y, output, clog2(IMG_H) bits: center-pixel row.
REQ-015 SHALL have port cell_op, output, 4 bits: latched opcode.
REQ-016 SHALL have port cell_user, output, 8 bits: latched immediate.
REQ-017 SHALL have port cell_last, output, 1 bit: the current request is the final cell of the pass.
REQ-018 SHALL have port res_valid, input, 1 bit: the cell processor presents a result pixel.
REQ-019 SHALL have port res_ready, output, 1 bit: the scheduler accepts the result.
REQ-020 SHALL have port busy, output, 1 bit: high in the ISSUE and DRAIN states.
REQ-021 SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes.
REQ-022 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal opcode or an aborted pass.

Function
REQ-023 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-024 IDLE: start=1 with opcode_in<=11 SHALL latch opcode_in and user_in, set x=y=HALF and go to ISSUE; cell_valid SHALL rise on the next cycle.
REQ-025 IDLE: start=1 with opcode_in>11 SHALL stay in IDLE and pulse err on the next cycle, with no cell issued.
REQ-026 start SHALL be ignored outside IDLE, and the latched opcode/user SHALL NOT change mid-pass.
REQ-027 A cell SHALL be transferred only on a cycle with cell_valid=1 and cell_ready=1; cell_x, cell_y and cell_last SHALL stay stable while cell_valid=1 and cell_ready=0.
REQ-028 Raster order: after each transfer x SHALL increment; when x=IMG_W-1-HALF, x SHALL wrap to HALF and y SHALL increment.
REQ-029 cell_last SHALL be high when x=IMG_W-1-HALF and y=IMG_H-1-HALF.
REQ-030 The total issued per pass SHALL be (IMG_W-2*HALF)*(IMG_H-2*HALF).
REQ-031 An outstanding counter SHALL count +1 per cell transfer, -1 per result transfer, and hold when both occur in the same cycle.
REQ-032 cell_valid SHALL be 0 when outstanding=MAX_OUT, unless a result transfer occurs in the same cycle.
REQ-033 res_ready SHALL equal (outstanding>0); res_valid with outstanding=0 SHALL be ignored.
REQ-034 A transfer of the cell_last request SHALL move the FSM to DRAIN.
REQ-035 abort=1 in ISSUE SHALL deassert cell_valid on the next cycle, go to DRAIN and record an aborted flag; an in-flight handshake on the abort cycle SHALL still complete.
REQ-036 DRAIN: cell_valid=0; when outstanding reaches 0 (including via a result on that cycle), the FSM SHALL go to DONE.
REQ-037 DONE (one cycle): done=1, plus err=1 if the pass was aborted; then return to IDLE.
REQ-038 abort in IDLE, DRAIN or DONE SHALL have no effect.

Reset
REQ-039 rst=1 SHALL force the IDLE state, outstanding=0, x=y=0, cell_op=0, cell_user=0, and the aborted flag cleared.
REQ-040 rst=1 SHALL drive cell_valid, cell_last, res_ready, busy, done and err to 0 on the following cycle.
REQ-041 rst SHALL take priority over all inputs, including mid-pass; results arriving after reset SHALL be ignored.

Verification
REQ-042 IMG_W=5, IMG_H=4, cell_ready=1, and each result returned 2 cycles after its issue -> cells issued as (1,1),(2,1),(3,1),(1,2),(2,2),(3,2), cell_last only on (3,2), done pulse once, err=0.
REQ-043 MAX_OUT=2, cell_ready=1, res_valid=0 -> exactly 2 transfers and cell_valid then 0; a single res_valid pulse -> exactly one more transfer.
REQ-044 cell_ready low for 3 cycles at (2,1) -> cell_x=2 and cell_y=1 held all 3 cycles, with no skipped or duplicated cell.
REQ-045 start with opcode_in=13 -> err pulses 1 cycle later, busy stays 0, no cell_valid.
REQ-046 abort after 2 transfers with 2 results outstanding -> no further cell_valid; after the 2 results, done=1 and err=1 in the same cycle.
REQ-047 rst asserted mid-ISSUE with outstanding=3 -> next cycle all outputs 0; a subsequent start begins at (1,1) with outstanding=0.
